line_buf_scheduler: RTL and testbench
=====================================

// Module: line_buf_scheduler
// PURPOSE
//  Time-slot scheduler that shares one single-port ping-pong line RAM between the
//  pixel-capture writer (one pixel per dot, every 4th clk_dot4x) and the VGA/HDMI
//  scan-out reader (one pixel per 2 clk_dot4x). Sits between the VIC pixel pipeline
//  and the scan-doubler output stage, replacing dual-ported line buffers with one RAM.
// PARAMETERS
//  ADDR_W  10   pixel address width per bank
//  DATA_W  4    pixel colour width
//  DEPTH   520  valid pixel slots per bank (covers the widest chip line)
// PORTS
//  clk_dot4x  in   1       4x dot clock
//  rst        in   1       synchronous, active-high reset
//  line_start in   1       1-cycle pulse at raster_x==0; swaps write/read banks
//  wr_req     in   1       1-cycle pixel-capture write request
//  wr_addr    in   ADDR_W  capture pixel index
//  wr_data    in   DATA_W  capture pixel colour
//  rd_req     in   1       1-cycle scan-out read request
//  rd_addr    in   ADDR_W  scan-out pixel index
//  rd_data    out  DATA_W  read result
//  rd_valid   out  1       rd_data valid strobe (1 cycle)
//  wr_bank    out  1       bank currently written; reads use ~wr_bank
//  ram_addr   out  ADDR_W+1  {bank, addr} to single-port RAM
//  ram_we     out  1       RAM write enable
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data, 1-cycle registered latency
//  ovr_err    out  1       sticky: request lost (overwritten while pending)
//  addr_err   out  1       sticky: request with addr >= DEPTH
// BEHAVIOUR
//  - Reset: phase=0, wr_bank=0, no pending requests, all outputs 0 (rd_data=0).
//  - 2-bit free-running phase counter. Slot map: phase0=WRITE, phase1=READ,
//    phase2=SPARE (idle / debug), phase3=READ.
//  - Each requester has a 1-entry pending register {valid, bank, addr, data}; bank
//    latched at request time (write: wr_bank, read: ~wr_bank as of that cycle).
//  - In its slot, a pending request drives ram_addr/ram_we/ram_wdata for that cycle
//    and its pending bit clears. Non-slot cycles: ram_we=0, ram_addr holds last value.
//  - Request arriving the same cycle as its own slot with no pending entry is
//    issued directly (bypass, zero wait).
//  - New request while same-requester entry pending (not issued this cycle): newer
//    replaces older, ovr_err set. Request in the same cycle the pending one issues:
//    no error, new one becomes pending.
//  - Read latency: rd_valid pulses exactly 1 cycle after the read slot used;
//    rd_data holds until next rd_valid.
//  - addr >= DEPTH: write is dropped (ram_we stays 0 in slot), read returns rd_data=0
//    with normal rd_valid timing; addr_err set in both cases.
//  - line_start toggles wr_bank on the next cycle; already-pending requests keep
//    their latched bank. line_start coincident with wr_req: request uses old bank.
//  - Worst-case write wait 3 cycles, read wait 1 cycle; with nominal rates (1 wr /4,
//    1 rd /2) no overrun occurs.
//  - Sticky errors clear only on rst. rst mid-operation discards pending entries,
//    suppresses any in-flight rd_valid.
// CONFIGURATION
//  LINEBUF_DEBUG_PORT_EN defined: adds ports dbg_req (in 1), dbg_addr (in ADDR_W+1,
//   absolute {bank,addr}), dbg_data (out DATA_W), dbg_valid (out 1). dbg request is
//   pending until phase2, dbg_valid 1 cycle later; same overwrite/addr rules, no
//   ovr_err contribution. Used for register-mapped line-buffer readback.
//  Not defined: phase2 is always idle; no dbg ports exist.
// TESTING
//  1. Reset then idle 16 cycles -> ram_we never 1, rd_valid never 1, errors 0.
//  2. wr_req addr=5 data=0xA at phase1 -> ram_we=1, ram_addr={0,5}, wdata=0xA at
//     next phase0 (3 cycles later); no ovr_err.
//  3. Write addr=7 data=0x3, line_start, rd_req addr=7 -> rd_valid 1 cycle after next
//     read slot with rd_data=0x3, ram_addr={0,7} on read.
//  4. Two wr_req 1 cycle apart before phase0 -> only second written, ovr_err=1.
//  5. wr_req addr=600 and rd_req addr=520 -> no write, rd_data=0 with rd_valid,
//     addr_err=1.
//  6. Nominal streaming 520 writes (every 4th cycle) + 1040 reads (every 2nd) across
//     4 line_starts -> every read returns pixel written previous line, no errors;
//     with LINEBUF_DEBUG_PORT_EN, dbg read of {1,5} served only in phase2.

Source files
------------

// File: rtl/line_buf_scheduler.sv
// Slot arbiter sharing one single-port ping-pong line RAM between pixel capture and scan-out.
// Optional register-mapped readback port in the spare slot: define LINEBUF_DEBUG_PORT_EN.
module line_buf_scheduler #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 520
) (
   input  logic              clk_dot4x,
   input  logic              rst,
   input  logic              i_line_start,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   output logic              o_wr_bank,
   output logic [ADDR_W:0]   o_ram_addr,
   output logic              o_ram_we,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_ovr_err,
   output logic              o_addr_err
`ifdef LINEBUF_DEBUG_PORT_EN
   ,
   input  logic              i_dbg_req,
   input  logic [ADDR_W:0]   i_dbg_addr,
   output logic [DATA_W-1:0] o_dbg_data,
   output logic              o_dbg_valid
`endif
);

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      SLOT_WR    = 2'd0,
      SLOT_RD_A  = 2'd1,
      SLOT_SPARE = 2'd2,
      SLOT_RD_B  = 2'd3
   } slot_t;

   slot_t r_slot, w_slot_next;

   logic              r_wr_bank;
   logic              r_wp_vld, r_wp_bank;
   logic [ADDR_W-1:0] r_wp_addr;
   logic [DATA_W-1:0] r_wp_data;
   logic              r_rp_vld, r_rp_bank;
   logic [ADDR_W-1:0] r_rp_addr;
   logic [ADDR_W:0]   r_ram_addr;
   logic              r_rd_vld, r_rd_zero;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_ovr_err, r_addr_err;

   logic              w_wr_slot, w_rd_slot;
   logic              w_wr_issue, w_rd_issue, w_wr_ok, w_rd_ok;
   logic              w_wr_load, w_rd_load, w_wr_ovr, w_rd_ovr, w_req_bad;
   logic              w_wr_bank_sel, w_rd_bank_sel;
   logic [ADDR_W-1:0] w_wr_addr_sel, w_rd_addr_sel;
   logic [DATA_W-1:0] w_wr_data_sel, w_rd_data_now;
   logic              w_rd_vld;
   logic              w_dbg_ok, w_dbg_bad;
   logic [ADDR_W:0]   w_dbg_addr_sel;

   always_ff @(posedge clk_dot4x) begin
      if (rst) r_slot <= SLOT_WR;
      else     r_slot <= w_slot_next;
   end

   always_comb begin
      w_slot_next = SLOT_WR;
      case (r_slot)
         SLOT_WR:    w_slot_next = SLOT_RD_A;
         SLOT_RD_A:  w_slot_next = SLOT_SPARE;
         SLOT_SPARE: w_slot_next = SLOT_RD_B;
         SLOT_RD_B:  w_slot_next = SLOT_WR;
         default:    w_slot_next = SLOT_WR;
      endcase
   end

   assign w_wr_slot = (r_slot == SLOT_WR);
   assign w_rd_slot = (r_slot == SLOT_RD_A) || (r_slot == SLOT_RD_B);

   // A pending entry always wins its slot; an empty entry lets the live request bypass.
   assign w_wr_issue    = !rst && w_wr_slot && (r_wp_vld || i_wr_req);
   assign w_wr_bank_sel = r_wp_vld ? r_wp_bank : r_wr_bank;
   assign w_wr_addr_sel = r_wp_vld ? r_wp_addr : i_wr_addr;
   assign w_wr_data_sel = r_wp_vld ? r_wp_data : i_wr_data;
   assign w_wr_ok       = w_wr_issue && ({1'b0, w_wr_addr_sel} < LP_DEPTH);
   assign w_wr_load     = i_wr_req && !(w_wr_slot && !r_wp_vld);
   assign w_wr_ovr      = i_wr_req && r_wp_vld && !w_wr_slot;

   assign w_rd_issue    = !rst && w_rd_slot && (r_rp_vld || i_rd_req);
   assign w_rd_bank_sel = r_rp_vld ? r_rp_bank : ~r_wr_bank;
   assign w_rd_addr_sel = r_rp_vld ? r_rp_addr : i_rd_addr;
   assign w_rd_ok       = w_rd_issue && ({1'b0, w_rd_addr_sel} < LP_DEPTH);
   assign w_rd_load     = i_rd_req && !(w_rd_slot && !r_rp_vld);
   assign w_rd_ovr      = i_rd_req && r_rp_vld && !w_rd_slot;

   assign w_req_bad = (i_wr_req && ({1'b0, i_wr_addr} >= LP_DEPTH)) ||
                      (i_rd_req && ({1'b0, i_rd_addr} >= LP_DEPTH)) || w_dbg_bad;

   always_comb begin
      o_ram_we    = 1'b0;
      o_ram_wdata = '0;
      o_ram_addr  = r_ram_addr;
      if (w_wr_ok) begin
         o_ram_we    = 1'b1;
         o_ram_addr  = {w_wr_bank_sel, w_wr_addr_sel};
         o_ram_wdata = w_wr_data_sel;
      end else if (w_rd_ok) begin
         o_ram_addr = {w_rd_bank_sel, w_rd_addr_sel};
      end else if (w_dbg_ok) begin
         o_ram_addr = w_dbg_addr_sel;
      end
   end

   // RAM data arrives the cycle after the slot; it is forwarded then and held afterwards.
   assign w_rd_vld      = r_rd_vld && !rst;
   assign w_rd_data_now = r_rd_zero ? '0 : i_ram_rdata;
   assign o_rd_valid    = w_rd_vld;
   assign o_rd_data     = w_rd_vld ? w_rd_data_now : r_rd_data;
   assign o_wr_bank     = r_wr_bank;
   assign o_ovr_err     = r_ovr_err;
   assign o_addr_err    = r_addr_err;

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         r_wr_bank  <= 1'b0;
         r_wp_vld   <= 1'b0;
         r_wp_bank  <= 1'b0;
         r_wp_addr  <= '0;
         r_wp_data  <= '0;
         r_rp_vld   <= 1'b0;
         r_rp_bank  <= 1'b0;
         r_rp_addr  <= '0;
         r_ram_addr <= '0;
         r_rd_vld   <= 1'b0;
         r_rd_zero  <= 1'b0;
         r_rd_data  <= '0;
         r_ovr_err  <= 1'b0;
         r_addr_err <= 1'b0;
      end else begin
         r_wr_bank  <= r_wr_bank ^ i_line_start;
         r_ram_addr <= o_ram_addr;
         if (w_wr_load) begin
            r_wp_vld  <= 1'b1;
            r_wp_bank <= r_wr_bank;
            r_wp_addr <= i_wr_addr;
            r_wp_data <= i_wr_data;
         end else if (w_wr_slot) begin
            r_wp_vld <= 1'b0;
         end
         if (w_rd_load) begin
            r_rp_vld  <= 1'b1;
            r_rp_bank <= ~r_wr_bank;
            r_rp_addr <= i_rd_addr;
         end else if (w_rd_slot) begin
            r_rp_vld <= 1'b0;
         end
         r_rd_vld  <= w_rd_issue;
         r_rd_zero <= !w_rd_ok;
         if (r_rd_vld) r_rd_data <= w_rd_data_now;
         if (w_wr_ovr || w_rd_ovr) r_ovr_err <= 1'b1;
         if (w_req_bad) r_addr_err <= 1'b1;
      end
   end

`ifdef LINEBUF_DEBUG_PORT_EN
   logic              r_dp_vld;
   logic [ADDR_W:0]   r_dp_addr;
   logic              r_dbg_vld, r_dbg_zero;
   logic [DATA_W-1:0] r_dbg_data;
   logic              w_dbg_slot, w_dbg_issue, w_dbg_vld;
   logic [DATA_W-1:0] w_dbg_data_now;

   assign w_dbg_slot     = (r_slot == SLOT_SPARE);
   assign w_dbg_issue    = !rst && w_dbg_slot && (r_dp_vld || i_dbg_req);
   assign w_dbg_addr_sel = r_dp_vld ? r_dp_addr : i_dbg_addr;
   assign w_dbg_ok       = w_dbg_issue && ({1'b0, w_dbg_addr_sel[ADDR_W-1:0]} < LP_DEPTH);
   assign w_dbg_bad      = i_dbg_req && ({1'b0, i_dbg_addr[ADDR_W-1:0]} >= LP_DEPTH);
   assign w_dbg_vld      = r_dbg_vld && !rst;
   assign w_dbg_data_now = r_dbg_zero ? '0 : i_ram_rdata;
   assign o_dbg_valid    = w_dbg_vld;
   assign o_dbg_data     = w_dbg_vld ? w_dbg_data_now : r_dbg_data;

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         r_dp_vld   <= 1'b0;
         r_dp_addr  <= '0;
         r_dbg_vld  <= 1'b0;
         r_dbg_zero <= 1'b0;
         r_dbg_data <= '0;
      end else begin
         if (i_dbg_req && !(w_dbg_slot && !r_dp_vld)) begin
            r_dp_vld  <= 1'b1;
            r_dp_addr <= i_dbg_addr;
         end else if (w_dbg_slot) begin
            r_dp_vld <= 1'b0;
         end
         r_dbg_vld  <= w_dbg_issue;
         r_dbg_zero <= !w_dbg_ok;
         if (r_dbg_vld) r_dbg_data <= w_dbg_data_now;
      end
   end
`else
   assign w_dbg_ok       = 1'b0;
   assign w_dbg_bad      = 1'b0;
   assign w_dbg_addr_sel = '0;
`endif

endmodule

// File: tb/tb_line_buf_scheduler.sv
// Randomized self-checking bench for line_buf_scheduler against a slot-level reference model
// that keeps its own image of the line RAM. Covers LINEBUF_DEBUG_PORT_EN when defined.
module tb_line_buf_scheduler;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 4;
   localparam int DEPTH  = 520;

   logic              clkDot4x = 1'b0;
   logic              rst = 1'b1;
   logic              lineStart = 1'b0;
   logic              wrReq = 1'b0;
   logic [ADDR_W-1:0] wrAddr = '0;
   logic [DATA_W-1:0] wrData = '0;
   logic              rdReq = 1'b0;
   logic [ADDR_W-1:0] rdAddr = '0;
   logic [DATA_W-1:0] rdData;
   logic              rdValid;
   logic              wrBank;
   logic [ADDR_W:0]   ramAddr;
   logic              ramWe;
   logic [DATA_W-1:0] ramWdata;
   logic [DATA_W-1:0] ramRdata = '0;
   logic              ovrErr;
   logic              addrErr;
`ifdef LINEBUF_DEBUG_PORT_EN
   logic              dbgReq = 1'b0;
   logic [ADDR_W:0]   dbgAddr = '0;
   logic [DATA_W-1:0] dbgData;
   logic              dbgValid;
`endif

   always #5 clkDot4x = ~clkDot4x;

   line_buf_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk_dot4x   (clkDot4x),
      .rst         (rst),
      .i_line_start(lineStart),
      .i_wr_req    (wrReq),
      .i_wr_addr   (wrAddr),
      .i_wr_data   (wrData),
      .i_rd_req    (rdReq),
      .i_rd_addr   (rdAddr),
      .o_rd_data   (rdData),
      .o_rd_valid  (rdValid),
      .o_wr_bank   (wrBank),
      .o_ram_addr  (ramAddr),
      .o_ram_we    (ramWe),
      .o_ram_wdata (ramWdata),
      .i_ram_rdata (ramRdata),
      .o_ovr_err   (ovrErr),
      .o_addr_err  (addrErr)
`ifdef LINEBUF_DEBUG_PORT_EN
      ,
      .i_dbg_req   (dbgReq),
      .i_dbg_addr  (dbgAddr),
      .o_dbg_data  (dbgData),
      .o_dbg_valid (dbgValid)
`endif
   );

   // Single-port RAM with one cycle of registered read latency.
   logic [DATA_W-1:0] ram [0:2047];
   always @(posedge clkDot4x) begin
      if (ramWe) ram[ramAddr] <= ramWdata;
      ramRdata <= ram[ramAddr];
   end

   typedef struct {
      bit vld;
      bit bank;
      int addr;
      int data;
   } req_t;

   int   checks = 0;
   int   errors = 0;
   int   gold [0:2047];
   req_t mWp, mRp, mDp;
   int   mPhase;
   bit   mBank;
   int   mLastAddr;
   bit   mRdvNext, mDbgvNext;
   int   mRdNext, mRdHold, mDbgNext, mDbgHold;
   bit   mOvr, mAddrErr;
   bit   dbgReqIn = 1'b0;
   int   dbgAddrIn = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic int peek(input int absAddr);
      return ((absAddr % 1024) < DEPTH) ? gold[absAddr] : 0;
   endfunction

   // One clk_dot4x cycle: drive inputs, predict this cycle's outputs, compare, advance the model.
   task automatic applyStimulus(input bit wr, input int wa, input int wd, input bit rd, input int ra, input bit ls);
      req_t wrIn, rdIn, wServe, rServe, dServe, dbIn;
      bit   wServed, rServed, dServed, newRdv, newDbgv;
      int   expAddr, newRd, newDbg, expRd, expDbg;
      bit   expWe;
      int   expWdata;
      wrReq = wr; wrAddr = wa[ADDR_W-1:0]; wrData = wd[DATA_W-1:0];
      rdReq = rd; rdAddr = ra[ADDR_W-1:0]; lineStart = ls;
`ifdef LINEBUF_DEBUG_PORT_EN
      dbgReq = dbgReqIn; dbgAddr = dbgAddrIn[ADDR_W:0];
`endif
      #2;
      wrIn = '{wr, mBank, wa, wd};
      rdIn = '{rd, !mBank, ra, 0};
      dbIn = '{dbgReqIn, dbgAddrIn / 1024 == 1, dbgAddrIn % 1024, 0};
      expWe = 0; expWdata = 0; expAddr = mLastAddr;
      wServe.vld = 0; rServe.vld = 0; dServe.vld = 0;
      wServed = 0; rServed = 0; dServed = 0;
      newRdv = 0; newRd = 0; newDbgv = 0; newDbg = 0;
      if (mPhase == 0) begin
         if (mWp.vld) begin wServe = mWp; mWp.vld = 0; end
         else if (wr) begin wServe = wrIn; wServed = 1; end
      end
      if (mPhase % 2 == 1) begin
         if (mRp.vld) begin rServe = mRp; mRp.vld = 0; end
         else if (rd) begin rServe = rdIn; rServed = 1; end
      end
`ifdef LINEBUF_DEBUG_PORT_EN
      if (mPhase == 2) begin
         if (mDp.vld) begin dServe = mDp; mDp.vld = 0; end
         else if (dbgReqIn) begin dServe = dbIn; dServed = 1; end
      end
`endif
      if (wServe.vld && wServe.addr < DEPTH) begin
         expWe = 1; expWdata = wServe.data; expAddr = wServe.bank * 1024 + wServe.addr;
      end
      if (rServe.vld) begin
         newRdv = 1;
         newRd  = peek(rServe.bank * 1024 + rServe.addr);
         if (rServe.addr < DEPTH) expAddr = rServe.bank * 1024 + rServe.addr;
      end
      if (dServe.vld) begin
         newDbgv = 1;
         newDbg  = peek(dServe.bank * 1024 + dServe.addr);
         if (dServe.addr < DEPTH) expAddr = dServe.bank * 1024 + dServe.addr;
      end
      expRd  = mRdvNext ? mRdNext : mRdHold;
      expDbg = mDbgvNext ? mDbgNext : mDbgHold;

      checkOutput("ram_we", ramWe, expWe);
      checkOutput("ram_addr", ramAddr, expAddr);
      if (expWe) checkOutput("ram_wdata", ramWdata, expWdata);
      checkOutput("rd_valid", rdValid, mRdvNext);
      checkOutput("rd_data", rdData, expRd);
      checkOutput("wr_bank", wrBank, mBank);
      checkOutput("ovr_err", ovrErr, mOvr);
      checkOutput("addr_err", addrErr, mAddrErr);
`ifdef LINEBUF_DEBUG_PORT_EN
      checkOutput("dbg_valid", dbgValid, mDbgvNext);
      checkOutput("dbg_data", dbgData, expDbg);
`endif

      if (expWe) gold[expAddr] = expWdata;
      mLastAddr = expAddr;
      if (mRdvNext) mRdHold = expRd;
      if (mDbgvNext) mDbgHold = expDbg;
      mRdvNext = newRdv; mRdNext = newRd;
      mDbgvNext = newDbgv; mDbgNext = newDbg;
      // Arrivals not served this cycle wait in the slot queue, displacing any older entry.
      if (wr && !wServed) begin
         if (mWp.vld) mOvr = 1;
         mWp = wrIn;
      end
      if (rd && !rServed) begin
         if (mRp.vld) mOvr = 1;
         mRp = rdIn;
      end
`ifdef LINEBUF_DEBUG_PORT_EN
      if (dbgReqIn && !dServed) mDp = dbIn;
      if (dbgReqIn && (dbgAddrIn % 1024) >= DEPTH) mAddrErr = 1;
`endif
      if ((wr && wa >= DEPTH) || (rd && ra >= DEPTH)) mAddrErr = 1;
      if (ls) mBank = !mBank;
      mPhase = (mPhase + 1) % 4;
      dbgReqIn = 0;
      @(negedge clkDot4x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   task automatic doReset();
      @(negedge clkDot4x);
      rst = 1'b1; wrReq = 0; rdReq = 0; lineStart = 0;
      repeat (2) @(negedge clkDot4x);
      #2;
      checkOutput("rst_ram_we", ramWe, 0);
      checkOutput("rst_ram_addr", ramAddr, 0);
      checkOutput("rst_rd_valid", rdValid, 0);
      checkOutput("rst_rd_data", rdData, 0);
      checkOutput("rst_wr_bank", wrBank, 0);
      checkOutput("rst_ovr_err", ovrErr, 0);
      checkOutput("rst_addr_err", addrErr, 0);
      @(negedge clkDot4x);
      rst = 1'b0;
      mWp.vld = 0; mRp.vld = 0; mDp.vld = 0;
      mPhase = 0; mBank = 0; mLastAddr = 0;
      mRdvNext = 0; mRdNext = 0; mRdHold = 0;
      mDbgvNext = 0; mDbgNext = 0; mDbgHold = 0;
      mOvr = 0; mAddrErr = 0;
   endtask

   initial begin
      int off;
      for (int i = 0; i < 2048; i++) begin
         ram[i]  = '0;
         gold[i] = 0;
      end
      doReset();
      idle(16);

      idle(1);
      applyStimulus(1, 5, 'hA, 0, 0, 0);
      idle(4);

      applyStimulus(1, 7, 'h3, 0, 0, 0);
      idle(4);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 7, 0);
      idle(4);
      checkOutput("read_back_7", rdData, 'h3);

      applyStimulus(1, 600, 'h5, 0, 0, 0);
      idle(3);
      applyStimulus(0, 0, 0, 1, 520, 0);
      idle(3);
      checkOutput("bad_addr_flag", addrErr, 1);

      while (mPhase != 1) idle(1);
      applyStimulus(1, 9, 'h1, 0, 0, 0);
      applyStimulus(1, 10, 'h2, 0, 0, 0);
      idle(4);
      checkOutput("overrun_flag", ovrErr, 1);

      doReset();
      for (int line = 0; line < 5; line++) begin
         off = $urandom_range(1, 3);
         for (int c = 0; c < 2080; c++)
            applyStimulus(c % 4 == off, c / 4, $urandom_range(0, 15), c % 2 == 1, c / 4, c == 0 && line > 0);
      end
      checkOutput("stream_ovr", ovrErr, 0);
      checkOutput("stream_addr", addrErr, 0);

`ifdef LINEBUF_DEBUG_PORT_EN
      while (mPhase != 3) idle(1);
      dbgReqIn = 1; dbgAddrIn = 1024 + 5;
      idle(5);
`endif

      for (int i = 0; i < 4000; i++) begin
         dbgReqIn  = ($urandom % 8) == 0;
         dbgAddrIn = $urandom_range(0, 2047);
         applyStimulus(($urandom % 3) == 0,
                       (($urandom % 8) == 0) ? $urandom_range(520, 1023) : $urandom_range(0, 519),
                       $urandom_range(0, 15),
                       ($urandom % 2) == 0,
                       (($urandom % 8) == 0) ? $urandom_range(520, 1023) : $urandom_range(0, 519),
                       ($urandom % 64) == 0);
      end
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
